// File: rtl/clk_en_pkg.sv
// Shared definitions for the clock-enable generator: channel mode encoding and reset defaults.
// Optional fractional path is controlled by CLK_EN_GEN_FRAC_EN in the channel module.
package clk_en_pkg;

  typedef enum logic {
    MODE_INT  = 1'b0,
    MODE_FRAC = 1'b1
  } mode_e;

  localparam mode_e RST_MODE = MODE_INT;
  localparam int    RST_DIV  = 1;

endpackage

// File: rtl/clk_en_chan.sv
// One clock-enable channel: integer down-counter, plus a phase accumulator when CLK_EN_GEN_FRAC_EN is defined.
// Registered tick/sq (one cycle after the deciding edge); no backpressure, config commits at reload/tick, when idle, or on sync.
module clk_en_chan
  import clk_en_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic             wr_mode,
  input  logic [ACC_W-1:0] wr_val,
  output logic             tick,
  output logic             sq,
  output logic             pend
);

`ifdef CLK_EN_GEN_FRAC_EN
  localparam int VAL_W = ACC_W;
`else
  localparam int VAL_W = DIV_W;
`endif

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic [VAL_W-1:0] pval_q, pval_d;
  logic [VAL_W-1:0] wr_v, nval;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             commit;

`ifdef CLK_EN_GEN_FRAC_EN
  mode_e            mode_q, mode_d, pmode_q, pmode_d, nmode;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, val_q};
`else
  logic unused_cfg;

  // Mode and the upper value bits have no meaning without the accumulator.
  assign unused_cfg = ^{wr_mode, wr_val};
`endif

  assign wr_v = wr_val[VAL_W-1:0];

  // Divisor 0 runs as divisor 1, so both reload to 0.
  function automatic logic [DIV_W-1:0] reload_of(input logic [VAL_W-1:0] v);
    logic [DIV_W-1:0] d;
    d = v[DIV_W-1:0];
    return (d == '0) ? '0 : d - DIV_W'(1);
  endfunction

  always_comb begin
    cnt_d  = cnt_q;
    val_d  = val_q;
    pval_d = pval_q;
    pend_d = pend_q;
    tick_d = 1'b0;
    sq_d   = sq_q;
    commit = 1'b0;
    nval   = pval_q;
`ifdef CLK_EN_GEN_FRAC_EN
    mode_d  = mode_q;
    pmode_d = pmode_q;
    acc_d   = acc_q;
    nmode   = pmode_q;
`endif

    if (sync) begin
      commit = wr | pend_q;
      if (wr) begin
        nval = wr_v;
`ifdef CLK_EN_GEN_FRAC_EN
        nmode = mode_e'(wr_mode);
`endif
      end
      sq_d = 1'b0;
    end else if (!en) begin
      commit = pend_q;
`ifdef CLK_EN_GEN_FRAC_EN
    end else if (mode_q == MODE_FRAC) begin
      acc_d  = sum[ACC_W-1:0];
      tick_d = sum[ACC_W];
      commit = pend_q & sum[ACC_W];
`endif
    end else begin
      if (cnt_q == '0) begin
        tick_d = 1'b1;
        cnt_d  = reload_of(val_q);
        commit = pend_q;
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
    end

    if (sync) begin
      cnt_d = reload_of(val_q);
`ifdef CLK_EN_GEN_FRAC_EN
      acc_d = '0;
`endif
    end else begin
      sq_d = sq_q ^ tick_d;
    end

    // A committed config always starts a fresh period in its own mode.
    if (commit) begin
      val_d = nval;
      cnt_d = reload_of(nval);
`ifdef CLK_EN_GEN_FRAC_EN
      mode_d = nmode;
      acc_d  = '0;
`endif
    end

    if (sync) begin
      pend_d = 1'b0;
    end else if (wr) begin
      pval_d = wr_v;
      pend_d = 1'b1;
`ifdef CLK_EN_GEN_FRAC_EN
      pmode_d = mode_e'(wr_mode);
`endif
    end else if (commit) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      val_q  <= VAL_W'(RST_DIV);
      pval_q <= '0;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      val_q  <= val_d;
      pval_q <= pval_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

`ifdef CLK_EN_GEN_FRAC_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q  <= RST_MODE;
      pmode_q <= RST_MODE;
      acc_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      pmode_q <= pmode_d;
      acc_q   <= acc_d;
    end
  end
`endif

  assign tick = tick_q;
  assign sq   = sq_q;
  assign pend = pend_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator; fractional mode compiled in with CLK_EN_GEN_FRAC_EN.
// Outputs registered, one cycle after the deciding edge; no backpressure, writes to absent channels are dropped.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16,
  parameter int ACC_W  = 24,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_mode,
  input  logic [ACC_W-1:0]  cfg_val,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] pend
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_i;

    // An index with no matching channel simply selects nothing.
    assign wr_i = cfg_wr && (cfg_ch == CH_W'(i));

    clk_en_chan #(
      .DIV_W (DIV_W),
      .ACC_W (ACC_W)
    ) u_chan (
      .clock   (clock),
      .reset   (reset),
      .en      (ch_en[i]),
      .sync    (sync),
      .wr      (wr_i),
      .wr_mode (cfg_mode),
      .wr_val  (cfg_val),
      .tick    (tick[i]),
      .sq      (sq[i]),
      .pend    (pend[i])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen with a cycle-level model based on period counting.
module tb_clk_en_gen;

  localparam int     NCH  = 4;
  localparam longint WRAP = 64'd1 << 24;
`ifdef CLK_EN_GEN_FRAC_EN
  localparam bit FRAC = 1'b1;
`else
  localparam bit FRAC = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic [NCH-1:0] ch_en;
  logic           sync;
  logic           cfg_wr;
  logic [1:0]     cfg_ch;
  logic           cfg_mode;
  logic [23:0]    cfg_val;
  logic [NCH-1:0] tick, sq, pend;

  int n_vec = 0;
  int n_err = 0;

  clk_en_gen #(.NUM_CH(NCH), .DIV_W(16), .ACC_W(24)) dut (
    .clock    (clock),
    .reset    (reset),
    .ch_en    (ch_en),
    .sync     (sync),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_val  (cfg_val),
    .tick     (tick),
    .sq       (sq),
    .pend     (pend)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int eff_div(input longint v);
    int d;
    d = int'(v & 64'hFFFF);
    return (d == 0) ? 1 : d;
  endfunction

  // Model: count enabled cycles within the current period; a tick ends the period.
  int             m_ph   [NCH];
  longint         m_acc  [NCH];
  longint         m_val  [NCH];
  longint         m_pval [NCH];
  logic [NCH-1:0] m_mode, m_pmode, m_pend, m_tick, m_sq;

  always @(posedge clock or posedge reset) begin : model
    int     ph;
    longint acc, val, pval;
    bit     md, pmd, pd, t, s, wr_i, wm, cm;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_ph[i]   <= 0;
        m_acc[i]  <= 0;
        m_val[i]  <= 1;
        m_pval[i] <= 0;
      end
      m_mode  <= '0;
      m_pmode <= '0;
      m_pend  <= '0;
      m_tick  <= '0;
      m_sq    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ph = m_ph[i]; acc = m_acc[i]; val = m_val[i]; pval = m_pval[i];
        md = m_mode[i]; pmd = m_pmode[i]; pd = m_pend[i]; s = m_sq[i];
        t = 1'b0; cm = 1'b0;
        wr_i = cfg_wr && (int'(cfg_ch) == i);
        wm = FRAC && cfg_mode;
        if (sync) begin
          if (wr_i) begin pval = longint'(cfg_val); pmd = wm; pd = 1'b1; end
          if (pd) begin val = pval; md = pmd; pd = 1'b0; end
          ph = 0; acc = 0; s = 1'b0;
        end else begin
          if (!ch_en[i]) begin
            cm = pd;
          end else if (md) begin
            acc = acc + val;
            if (acc >= WRAP) begin acc = acc - WRAP; t = 1'b1; cm = pd; end
          end else begin
            ph = ph + 1;
            if (ph >= eff_div(val)) begin ph = 0; t = 1'b1; cm = pd; end
          end
          if (cm) begin val = pval; md = pmd; ph = 0; acc = 0; pd = 1'b0; end
          s = s ^ t;
          if (wr_i) begin pval = longint'(cfg_val); pmd = wm; pd = 1'b1; end
        end
        m_ph[i]   <= ph;
        m_acc[i]  <= acc;
        m_val[i]  <= val;
        m_pval[i] <= pval;
        m_mode[i] <= md;
        m_pmode[i] <= pmd;
        m_pend[i] <= pd;
        m_tick[i] <= t;
        m_sq[i]   <= s;
      end
    end
  end

  always @(negedge clock) begin
    chk("model_tick", 32'(tick), 32'(m_tick));
    chk("model_sq",   32'(sq),   32'(m_sq));
    chk("model_pend", 32'(pend), 32'(m_pend));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr_cfg(input int ch, input bit mode, input logic [23:0] v);
    cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_mode = mode; cfg_val = v;
    step(1);
    cfg_wr = 1'b0;
  endtask

  logic [8:0]     pat_t, pat_s, pat_p;
  logic [NCH-1:0] sync_exp [6];

  initial begin
    sync_exp[0] = 4'b0001; sync_exp[1] = 4'b0101; sync_exp[2] = 4'b0011;
    sync_exp[3] = 4'b0101; sync_exp[4] = 4'b1001; sync_exp[5] = 4'b0111;
    reset = 1'b1; ch_en = '0; sync = 1'b0; cfg_wr = 1'b0;
    cfg_ch = '0; cfg_mode = 1'b0; cfg_val = '0;
    step(2);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_sq",   32'(sq),   32'h0);
    chk("rst_pend", 32'(pend), 32'h0);

    // Default D=1 on ch0: tick every cycle from the first edge.
    reset = 1'b0; ch_en = 4'b0001;
    step(1);
    chk("d1_tick_c1", 32'(tick), 32'h1);
    chk("d1_sq_c1",   32'(sq),   32'h1);
    step(1);
    chk("d1_tick_c2", 32'(tick), 32'h1);
    chk("d1_sq_c2",   32'(sq),   32'h0);

    // ch1 D=3 written while idle, then enabled.
    wr_cfg(1, 1'b0, 24'd3);
    chk("d3_pend_set", 32'(pend[1]), 32'h1);
    step(1);
    chk("d3_pend_clr", 32'(pend[1]), 32'h0);
    ch_en = 4'b0011;
    pat_t = '0; pat_s = '0;
    for (int k = 0; k < 9; k++) begin
      step(1);
      pat_t[k] = tick[1];
      pat_s[k] = sq[1];
    end
    chk("d3_tick_pat", 32'(pat_t), 32'h124);
    chk("d3_sq_pat",   32'(pat_s), 32'h11C);

    // ch2 D=4 running, rewritten to D=2 mid-count.
    wr_cfg(2, 1'b0, 24'd4);
    step(1);
    ch_en = 4'b0111;
    pat_t = '0; pat_p = '0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      pat_t[k] = tick[2];
      pat_p[k] = pend[2];
      if (k == 1) begin
        cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_mode = 1'b0; cfg_val = 24'd2;
      end else begin
        cfg_wr = 1'b0;
      end
    end
    chk("d4to2_tick_pat", 32'(pat_t), 32'hA8);
    chk("d4to2_pend_pat", 32'(pat_p), 32'h04);

    // Last write wins, upper value bits, D=0, repeated writes across commit edges.
    wr_cfg(1, 1'b0, 24'd5);
    wr_cfg(1, 1'b0, 24'h010003);
    wr_cfg(0, 1'b0, 24'd0);
    for (int k = 0; k < 4; k++) wr_cfg(2, 1'b0, 24'(3 + k) & 24'h7);
    wr_cfg(2, 1'b0, 24'd2);
    step(8);

    // Freeze ch1 and resume.
    ch_en = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("freeze_tick1", 32'(tick[1]), 32'h0);
    end
    ch_en = 4'b0111;
    step(7);

    // Sync with a same-cycle write to ch3.
    ch_en = 4'b1111;
    step(5);
    sync = 1'b1; cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_mode = 1'b0; cfg_val = 24'd5;
    step(1);
    sync = 1'b0; cfg_wr = 1'b0;
    chk("sync_tick", 32'(tick), 32'h0);
    chk("sync_sq",   32'(sq),   32'h0);
    chk("sync_pend", 32'(pend), 32'h0);
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk($sformatf("sync_align_c%0d", k + 1), 32'(tick), 32'(sync_exp[k]));
    end

    // Asynchronous reset while ch1 holds a pending write.
    wr_cfg(1, 1'b0, 24'd7);
    chk("prerst_pend1", 32'(pend[1]), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst_tick", 32'(tick), 32'h0);
    chk("arst_sq",   32'(sq),   32'h0);
    chk("arst_pend", 32'(pend), 32'h0);
    step(2);
    reset = 1'b0;
    step(1);
    chk("postrst_tick_c1", 32'(tick), 32'hF);
    chk("postrst_sq_c1",   32'(sq),   32'hF);
    step(1);
    chk("postrst_tick_c2", 32'(tick), 32'hF);
    chk("postrst_sq_c2",   32'(sq),   32'h0);

`ifdef CLK_EN_GEN_FRAC_EN
    ch_en = '0;
    wr_cfg(0, 1'b1, 24'h400000);
    step(1);
    ch_en = 4'b0001;
    pat_t = '0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      pat_t[k] = tick[0];
    end
    chk("frac_quarter_pat", 32'(pat_t), 32'h88);
    ch_en = '0;
    wr_cfg(0, 1'b1, 24'h555556);
    step(1);
    ch_en = 4'b0001;
    pat_t = '0;
    for (int k = 0; k < 9; k++) begin
      step(1);
      pat_t[k] = tick[0];
    end
    chk("frac_third_pat",   32'(pat_t), 32'h124);
    chk("frac_third_count", 32'($countones(pat_t)), 32'h3);
`endif

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
